// File: rtl/mux4_rr_arbiter.sv
// Round-robin 4:1 arbiter: one IDLE cycle picks a requester, then GRANT forwards its stream combinationally.
// Backpressure: out_ready is passed straight to the granted in_ready; no buffering.
module mux4_rr_arbiter #(
   parameter int DW       = 8,
   parameter int MAXBURST = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      in_valid,
   input  logic [4*DW-1:0] in_data,
   input  logic [3:0]      in_last,
   output logic [3:0]      in_ready,
   output logic            out_valid,
   output logic [DW-1:0]   out_data,
   output logic            out_last,
   input  logic            out_ready,
   output logic [1:0]      sel,
   output logic            busy
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   localparam logic [3:0] LAST_BEAT = 4'(MAXBURST - 1);

   logic [0:0] state;
   logic [1:0] ptr;
   logic [3:0] count;

   logic       found;
   logic [1:0] pick;
   logic [1:0] idx;
   logic       granted;
   logic       xfer;

   // Search starts at ptr so the last-served requester is considered last.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      idx   = '0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign granted = (state == GRANT);
   assign busy    = granted;

   always_comb begin
      out_data = '0;
      for (int k = 0; k < 4; k++) begin
         if (sel == 2'(k)) out_data = in_data[k*DW +: DW];
      end
   end

   assign out_valid = granted && in_valid[sel];
   assign out_last  = granted && (in_last[sel] || (count == LAST_BEAT));
   assign in_ready  = (granted && out_ready) ? (4'b0001 << sel) : 4'b0000;
   assign xfer      = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sel   <= 2'd0;
         ptr   <= 2'd0;
         count <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  sel   <= pick;
                  count <= 4'd0;
                  state <= GRANT;
               end
            end
            default: begin
               if (xfer) begin
                  if (out_last) begin
                     state <= IDLE;
                     ptr   <= sel + 2'd1;
                     count <= 4'd0;
                  end else begin
                     count <= count + 4'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule
